// File: rtl/reg_write_scoreboard.sv
// Producer-side register write scoreboard: per-register pending-write counters fed by
// issue, retire and cancel ports, producing busy bits, a RAW stall and issue back-pressure.
module reg_write_scoreboard #(
    parameter int NREG      = 16,
    parameter int CNT_W     = 2,
    parameter bit IGNORE_PC = 1'b1,
    parameter bit WB_BYPASS = 1'b1,
    localparam int IDX_W    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_wb_en,
    input  logic [IDX_W-1:0] issue_dest,
    output logic             issue_ready,
    input  logic             retire_valid,
    input  logic [IDX_W-1:0] retire_dest,
    input  logic             cancel_valid,
    input  logic [IDX_W-1:0] cancel_dest,
    input  logic [IDX_W-1:0] src_1,
    input  logic [IDX_W-1:0] src_2,
    input  logic             two_src,
    output logic             hazard_stall,
    output logic [NREG-1:0]  busy,
    output logic [5:0]       pending_total,
    output logic             err_underflow
);

    localparam int               PC_REG  = 15;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec_r;
    logic [NREG-1:0]  dec_c;
    logic [NREG-1:0]  uflow;
    logic [NREG-1:0]  pend;

    // Register 15 is the PC when IGNORE_PC is set; it never enters the scoreboard.
    function automatic logic tracked(input int r);
        return !(IGNORE_PC && (r == PC_REG));
    endfunction

    // Back-pressure looks only at the current count; same-cycle decrements do not free a slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        issue_ready = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if (issue_dest == IDX_W'(r) && cnt[r] == CNT_MAX) begin
                issue_ready = 1'b0;
            end
        end
    end

    always_comb begin
        inc   = '0;
        dec_r = '0;
        dec_c = '0;
        for (int r = 0; r < NREG; r++) begin
            if (tracked(r)) begin
                inc[r]   = issue_valid && issue_wb_en && issue_ready && (issue_dest == IDX_W'(r));
                dec_r[r] = retire_valid && (retire_dest == IDX_W'(r));
                dec_c[r] = cancel_valid && (cancel_dest == IDX_W'(r));
            end
        end
    end

    // All three ports apply together; a net decrement past zero clamps and flags underflow.
    always_comb begin : next_calc
        logic [CNT_W:0] up;
        logic [CNT_W:0] dn;
        for (int r = 0; r < NREG; r++) begin
            up = {1'b0, cnt[r]} + {{CNT_W{1'b0}}, inc[r]};
            dn = {{CNT_W{1'b0}}, dec_r[r]} + {{CNT_W{1'b0}}, dec_c[r]};
            if (up < dn) begin
                cnt_nxt[r] = '0;
                uflow[r]   = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(up - dn);
                uflow[r]   = 1'b0;
            end
        end
    end

    // NOTE: the counters are a handful of flops, not a RAM, so they take the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every counter sees pre-edge values.
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            if (|uflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // The register file writes in the first half-cycle, so a last write retiring now is readable.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
            pend[r] = busy[r] && !(WB_BYPASS && cnt[r] == CNT_W'(1) && dec_r[r]);
        end
    end

    always_comb begin
        hazard_stall = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (pend[r] && ((src_1 == IDX_W'(r)) || (two_src && src_2 == IDX_W'(r)))) begin
                hazard_stall = 1'b1;
            end
        end
    end

    always_comb begin : total_calc
        logic [31:0] acc;
        acc = '0;
        for (int r = 0; r < NREG; r++) begin
            acc = acc + 32'(cnt[r]);
        end
        pending_total = (acc > 32'd63) ? 6'd63 : acc[5:0];
    end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard: instance a uses default parameters,
// instance b disables the PC exclusion and the write-back bypass, both on shared stimulus.
module tb_reg_write_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid, issue_wb_en;
    logic [3:0]  issue_dest;
    logic        retire_valid, cancel_valid;
    logic [3:0]  retire_dest, cancel_dest;
    logic [3:0]  src_1, src_2;
    logic        two_src;

    logic        ready_a, hazard_a, err_a;
    logic [15:0] busy_a;
    logic [5:0]  total_a;
    logic        ready_b, hazard_b, err_b;
    logic [15:0] busy_b;
    logic [5:0]  total_b;

    int total;
    int bad;

    reg_write_scoreboard dut_a (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .issue_ready(ready_a),
        .retire_valid(retire_valid), .retire_dest(retire_dest),
        .cancel_valid(cancel_valid), .cancel_dest(cancel_dest),
        .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .hazard_stall(hazard_a), .busy(busy_a), .pending_total(total_a),
        .err_underflow(err_a)
    );

    reg_write_scoreboard #(.IGNORE_PC(1'b0), .WB_BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .issue_ready(ready_b),
        .retire_valid(retire_valid), .retire_dest(retire_dest),
        .cancel_valid(cancel_valid), .cancel_dest(cancel_dest),
        .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .hazard_stall(hazard_b), .busy(busy_b), .pending_total(total_b),
        .err_underflow(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_wb_en  = 1'b0;
        retire_valid = 1'b0;
        cancel_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] d);
        issue_valid = 1'b1;
        issue_wb_en = 1'b1;
        issue_dest  = d;
    endtask

    task automatic retire(input logic [3:0] d);
        retire_valid = 1'b1;
        retire_dest  = d;
    endtask

    task automatic cancel(input logic [3:0] d);
        cancel_valid = 1'b1;
        cancel_dest  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        issue_dest  = 4'd0;
        retire_dest = 4'd0;
        cancel_dest = 4'd0;
        src_1       = 4'd0;
        src_2       = 4'd0;
        two_src     = 1'b0;
        #2;
        check("reset_busy", 32'(busy_a), 32'h0);
        check("reset_total", 32'(total_a), 32'd0);
        check("reset_hazard", 32'(hazard_a), 32'd0);
        check("reset_ready", 32'(ready_a), 32'd1);
        check("reset_err", 32'(err_a), 32'd0);
        rst = 1'b0;
        tick();

        // Issue r3: invisible this cycle, visible next cycle.
        issue(4'd3);
        src_1 = 4'd3;
        settle();
        check("issue_same_cycle_hazard", 32'(hazard_a), 32'd0);
        tick();
        idle();
        settle();
        check("issue_r3_busy", 32'(busy_a), 32'h0008);
        check("issue_r3_hazard", 32'(hazard_a), 32'd1);
        check("issue_r3_total", 32'(total_a), 32'd1);

        // Retire r3: bypass clears the hazard now, busy stays until the edge.
        retire(4'd3);
        settle();
        check("retire_r3_bypass_hazard", 32'(hazard_a), 32'd0);
        check("retire_r3_nobypass_hazard", 32'(hazard_b), 32'd1);
        check("retire_r3_busy_held", 32'(busy_a), 32'h0008);
        tick();
        idle();
        settle();
        check("retire_r3_busy_after", 32'(busy_a), 32'h0);

        // Saturate r5 at 3, then a fourth issue is refused.
        issue(4'd5);
        tick();
        tick();
        tick();
        check("r5_sat_ready", 32'(ready_a), 32'd0);
        check("r5_sat_total", 32'(total_a), 32'd3);
        tick();
        issue_valid = 1'b0;
        issue_wb_en = 1'b0;
        retire(4'd5);
        settle();
        check("r5_blocked_total", 32'(total_a), 32'd3);
        check("r5_ready_ignores_retire", 32'(ready_a), 32'd0);
        tick();
        retire_valid = 1'b0;
        settle();
        check("r5_ready_after_retire", 32'(ready_a), 32'd1);
        check("r5_total_after_retire", 32'(total_a), 32'd2);
        retire(4'd5);
        tick();
        tick();
        idle();
        settle();
        check("r5_drained", 32'(total_a), 32'd0);

        // cnt[7]=1 retiring: src_2 bypass on a, stall on b.
        issue(4'd7);
        tick();
        idle();
        retire(4'd7);
        src_1   = 4'd0;
        src_2   = 4'd7;
        two_src = 1'b1;
        settle();
        check("r7_src2_bypass_hazard", 32'(hazard_a), 32'd0);
        check("r7_src2_nobypass_hazard", 32'(hazard_b), 32'd1);
        check("r7_busy_no_bypass", 32'(busy_a), 32'h0080);
        src_1   = 4'd7;
        two_src = 1'b0;
        settle();
        check("r7_src1_nobypass_hazard", 32'(hazard_b), 32'd1);
        tick();
        idle();
        src_1 = 4'd0;
        settle();
        check("r7_drained", 32'(total_a), 32'd0);

        // Issue and retire r2 in the same cycle with cnt 1: net zero.
        issue(4'd2);
        tick();
        retire(4'd2);
        tick();
        idle();
        settle();
        check("r2_same_cycle_busy", 32'(busy_a), 32'h0004);
        check("r2_same_cycle_total", 32'(total_a), 32'd1);
        check("r2_same_cycle_err", 32'(err_a), 32'd0);
        retire(4'd2);
        tick();
        idle();

        // Cancel r9 at zero: sticky underflow, counter clamps.
        cancel(4'd9);
        tick();
        idle();
        settle();
        check("cancel_r9_err", 32'(err_a), 32'd1);
        check("cancel_r9_clamp", 32'(total_a), 32'd0);
        tick();
        check("cancel_r9_err_sticky", 32'(err_a), 32'd1);

        // r15 is ignored on a, tracked on b.
        issue(4'd15);
        tick();
        idle();
        src_1 = 4'd15;
        settle();
        check("r15_busy_ignored", 32'(busy_a), 32'h0);
        check("r15_hazard_ignored", 32'(hazard_a), 32'd0);
        check("r15_total_ignored", 32'(total_a), 32'd0);
        check("r15_busy_tracked", 32'(busy_b), 32'h8000);
        check("r15_hazard_tracked", 32'(hazard_b), 32'd1);

        // Four pending writes, then an asynchronous reset between edges.
        issue(4'd1);
        tick();
        issue(4'd2);
        tick();
        issue(4'd3);
        tick();
        issue(4'd4);
        tick();
        idle();
        src_1 = 4'd1;
        settle();
        check("four_pending_total", 32'(total_a), 32'd4);
        check("four_pending_hazard", 32'(hazard_a), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy_a), 32'h0);
        check("async_rst_total", 32'(total_a), 32'd0);
        check("async_rst_hazard", 32'(hazard_a), 32'd0);
        check("async_rst_ready", 32'(ready_a), 32'd1);
        check("async_rst_err", 32'(err_a), 32'd0);
        check("async_rst_total_b", 32'(total_b), 32'd0);
        rst = 1'b0;

        // Retire to the ignored PC register never raises underflow.
        retire(4'd15);
        tick();
        idle();
        settle();
        check("r15_retire_no_err", 32'(err_a), 32'd0);

        // Retire and cancel together on cnt 1: clamps at 0 and flags underflow.
        issue(4'd4);
        tick();
        idle();
        retire(4'd4);
        cancel(4'd4);
        tick();
        idle();
        settle();
        check("dual_dec_total", 32'(total_a), 32'd0);
        check("dual_dec_busy", 32'(busy_a), 32'h0);
        check("dual_dec_err", 32'(err_a), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
